// File: rtl/layer_pkg.sv
// Shared widths and FSM encoding for the layer result writer.
package layer_pkg;

  localparam int PIX_W        = 32;
  localparam int CH_W         = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wr_addr_gen.sv
// Word/row counters for the result writer; turns the current position into a
// bank one-hot, a per-bank address and a last-word-of-frame flag.
module wr_addr_gen
  import layer_pkg::*;
#(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                adv,
  output logic [NUM_BANK-1:0] bank_oh,
  output logic [ADDR_W-1:0]   addr,
  output logic                last
);

  localparam int WORDS = IMG_W / PIX_PER_WORD;
  localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RC_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [RC_W-1:0] row_cnt_q, row_cnt_d;
  logic            word_last;
  logic            row_last;

  assign word_last = (word_cnt_q == WC_W'(WORDS - 1));
  assign row_last  = (row_cnt_q == RC_W'(IMG_H - 1));
  assign last      = word_last && row_last;

  always_comb begin
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    if (adv) begin
      if (word_last) begin
        word_cnt_d = '0;
        row_cnt_d  = row_last ? '0 : row_cnt_q + 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // Rows are interleaved across banks; each bank holds every NUM_BANK-th row.
  for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
    assign bank_oh[gi] = ((32'(row_cnt_q) % NUM_BANK) == gi);
  end

  assign addr = ADDR_W'((32'(row_cnt_q) / NUM_BANK) * WORDS + 32'(word_cnt_q));

endmodule

// File: rtl/layer_result_writer.sv
// Packs 4 conv-layer result pixels per 128-bit word and writes them row-interleaved
// into a 16-bank buffer. Optional sticky protocol-error flag oErr under LAYER_WR_ERR_EN.
module layer_result_writer
  import layer_pkg::*;
#(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                iStart,
  input  logic [PIX_W-1:0]    iLayer_result,
  input  logic                iLayer_vld,
  output logic [NUM_BANK-1:0] o_ena,
  output logic [ADDR_W-1:0]   o_addra,
  output logic [NUM_BANK-1:0] o_wea,
  output logic [WORD_W-1:0]   o_dia,
  output logic                oBusy,
  output logic                oDone
`ifdef LAYER_WR_ERR_EN
  ,
  output logic                oErr
`endif
);

  if ((IMG_W % PIX_PER_WORD) != 0) begin : g_bad_img_w
    $error("layer_result_writer: IMG_W must be a multiple of 4");
  end

  state_t                     state_q, state_d;
  logic [1:0]                 pix_cnt_q, pix_cnt_d;
  logic [3*PIX_W-1:0]         pix_buf_q, pix_buf_d;
  logic [NUM_BANK-1:0]        ena_q, ena_d;
  logic [ADDR_W-1:0]          addra_q, addra_d;
  logic [WORD_W-1:0]          dia_q, dia_d;
  logic                       done_q, done_d;

  logic                       accept;
  logic                       wr_fire;
  logic [NUM_BANK-1:0]        gen_bank_oh;
  logic [ADDR_W-1:0]          gen_addr;
  logic                       gen_last;

  assign accept  = (state_q == RUN) && iLayer_vld;
  assign wr_fire = accept && (pix_cnt_q == 2'd3);

  wr_addr_gen #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .NUM_BANK(NUM_BANK),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .adv    (wr_fire),
    .bank_oh(gen_bank_oh),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iStart) state_d = RUN;
      RUN:     if (wr_fire && gen_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixels shift in from the top so the first one ends up in the LSBs.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    pix_buf_d = pix_buf_q;
    ena_d     = '0;
    addra_d   = addra_q;
    dia_d     = dia_q;
    done_d    = 1'b0;
    if ((state_q == IDLE) && iStart) begin
      pix_cnt_d = '0;
    end
    if (accept) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      pix_buf_d = {iLayer_result, pix_buf_q[3*PIX_W-1:PIX_W]};
    end
    if (wr_fire) begin
      ena_d   = gen_bank_oh;
      addra_d = gen_addr;
      dia_d   = {iLayer_result, pix_buf_q};
      done_d  = gen_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pix_cnt_q <= '0;
      pix_buf_q <= '0;
      ena_q     <= '0;
      addra_q   <= '0;
      dia_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      pix_buf_q <= pix_buf_d;
      ena_q     <= ena_d;
      addra_q   <= addra_d;
      dia_q     <= dia_d;
      done_q    <= done_d;
    end
  end

  assign o_ena   = ena_q;
  assign o_wea   = ena_q;
  assign o_addra = addra_q;
  assign o_dia   = dia_q;
  assign oDone   = done_q;
  assign oBusy   = (state_q == RUN);

`ifdef LAYER_WR_ERR_EN
  logic err_q, err_d;

  // An accepted start clears the flag even if a stray vld arrives alongside it.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && iStart) begin
      err_d = 1'b0;
    end else if (((state_q == IDLE) && iLayer_vld) || ((state_q == RUN) && iStart)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign oErr = err_q;
`endif

endmodule
